// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle MULT/MULTU/DIV/DIVU engine for the EXE stage.
// Multiply uses one registered 64-bit product; divide is radix-2 restoring on magnitudes.
module hilo_muldiv #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken in IDLE when req_valid & !flush; the same
  // instruction stays in EXE (held by stall) until the single-cycle done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic        accept;

  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] prod_q;
  logic [31:0] quo_q, rem_q, dvs_q;

  logic        req_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b;
  logic [32:0] rem_sh;
  logic        sub_ok;
  logic [31:0] rem_n, quo_n;
  logic        op_signed, q_neg, r_neg;
  logic [31:0] res_hi, res_lo;

  assign dbg_state = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          stall  = 1'b1;
          if (req_op[1]) begin
            state_d = DIV;
            cnt_d   = 6'd0;
          end else begin
            state_d = MUL;
            cnt_d   = 6'd1;
          end
        end
      end
      MUL: begin
        stall = 1'b1;
        if (cnt == MUL_LAST) state_d = DONE;
        else                 cnt_d   = cnt + 6'd1;
      end
      DIV: begin
        stall = 1'b1;
        if (cnt == DIV_LAST) state_d = DONE;
        else                 cnt_d   = cnt + 6'd1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    // A killed instruction must leave no trace: no accept, no write, no stall.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      accept  = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Operand capture and magnitude conversion at accept time.
  assign req_signed = ~req_op[0];
  assign abs_a = (req_signed && src_a[31]) ? -src_a : src_a;
  assign abs_b = (req_signed && src_b[31]) ? -src_b : src_b;

  assign mul_a = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign mul_b = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem_q, quo_q[31]};
  assign sub_ok = rem_sh >= {1'b0, dvs_q};
  assign rem_n  = sub_ok ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
  assign quo_n  = {quo_q[30:0], sub_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 2'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      prod_q <= 64'd0;
      quo_q  <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        a_q   <= src_a;
        b_q   <= src_b;
        quo_q <= abs_a;
        dvs_q <= abs_b;
        rem_q <= 32'd0;
      end else if (state == DIV) begin
        quo_q <= quo_n;
        rem_q <= rem_n;
      end
      if (state == MUL) prod_q <= mul_a * mul_b;
    end
  end

  // Sign fixup: quotient sign is the XOR of operand signs, remainder follows the dividend.
  assign op_signed = ~op_q[0];
  assign q_neg     = op_signed & (a_q[31] ^ b_q[31]);
  assign r_neg     = op_signed & a_q[31];

  always_comb begin
    res_hi = prod_q[63:32];
    res_lo = prod_q[31:0];
    if (op_q[1]) begin
      if (b_q == 32'd0) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = r_neg ? -rem_q : rem_q;
        res_lo = q_neg ? -quo_q : quo_q;
      end
    end
  end

  // The EXE result is younger than any MTHI/MTLO in WB, so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (wb_hi_we) hi <= wb_wdata;
      if (wb_lo_we) lo <= wb_wdata;
    end
  end

endmodule
